// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer.
// Holds the FSM state encoding and the default widths of the counter value
// path and the completed-period counter.
package counter_seq_ctrl_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int PER_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Bundle between the sequencer and the loadable up-counter.
// Ports (through modports):
//   cnt_load : sequencer -> counter, load strobe
//   cnt_enab : sequencer -> counter, count enable
//   cnt_in   : sequencer -> counter, load value
//   cnt_out  : counter -> sequencer, registered count value
// The master modport is used by the sequencer and the slave modport by the counter.
interface counter_seq_ctrl_if #(
  parameter int CNT_W = 4
) ();

  logic             cnt_load;
  logic             cnt_enab;
  logic [CNT_W-1:0] cnt_in;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output cnt_load,
    output cnt_enab,
    output cnt_in,
    input  cnt_out
  );

  modport slave (
    input  cnt_load,
    input  cnt_enab,
    input  cnt_in,
    output cnt_out
  );

endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a loadable up-counter that sits beside it.
// When a start request is accepted, the block captures a start value and an
// end value. It loads the counter and enables it until the count reaches the
// end value. It then pulses done and either goes back to idle or, in
// auto-reload mode, reloads and repeats.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : run request, sampled only in IDLE
//   start_val     : load value, captured when start is accepted
//   end_val       : terminal count, captured when start is accepted
//   auto_reload   : repeat mode, captured when start is accepted
//   pause         : holds the counter enable low while in RUN
//   abort         : ends any active run
//   cnt           : counter bundle (load, enable, load value, count)
//   busy          : high in LOAD, RUN and DONE
//   done          : one-cycle pulse at each completed period
//   aborted       : one-cycle pulse in the cycle after an abort is taken
//   period_cnt    : completed periods since the last accepted start
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   start_val,
  input  logic [CNT_W-1:0]   end_val,
  input  logic               auto_reload,
  input  logic               pause,
  input  logic               abort,
  counter_seq_ctrl_if.master cnt,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [PER_W-1:0]   period_cnt
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] start_r;
  logic [CNT_W-1:0] end_r;
  logic             reload_r;
  logic             aborted_r;
  logic [PER_W-1:0] period_r;
  logic             load_c;
  logic             enab_c;
  logic             accept;
  logic             take_abort;
  logic             at_end;

  assign accept     = (state == IDLE) && start && !abort;
  assign take_abort = (state != IDLE) && abort;
  // The counter wraps on its own, so a plain equality covers end_r < start_r.
  assign at_end     = (cnt.cnt_out == end_r);

  // The state register and the captured run parameters.
  // aborted is registered so that its pulse lands in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_r   <= '0;
      end_r     <= '0;
      reload_r  <= 1'b0;
      aborted_r <= 1'b0;
      period_r  <= '0;
    end else begin
      state     <= state_next;
      aborted_r <= take_abort;
      if (accept) begin
        start_r  <= start_val;
        end_r    <= end_val;
        reload_r <= auto_reload;
        period_r <= '0;
      end else if (state == DONE && !abort) begin
        period_r <= period_r + 1'b1;
      end
    end
  end

  // Next-state logic and counter controls. An abort suppresses load, enable
  // and done in the same cycle and wins over any other transition.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    enab_c     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) state_next = IDLE;
        else begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) state_next = IDLE;
        else begin
          enab_c = !pause && !at_end;
          if (at_end) state_next = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (abort) state_next = IDLE;
        else begin
          done       = 1'b1;
          state_next = reload_r ? LOAD : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt.cnt_load = load_c;
  assign cnt.cnt_enab = enab_c;
  assign cnt.cnt_in   = start_r;
  assign aborted      = aborted_r;
  assign period_cnt   = period_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl. It places a loadable up-counter beside the
// sequencer and feeds the count back. Expected done events (cycle offset from
// start acceptance and the period count at that moment) are queued when a run
// is launched. They are checked when the DUT pulses done.
module tb_counter_seq_ctrl;

  localparam int CNT_W = 4;
  localparam int PER_W = 8;

  typedef struct {
    int cycle;
    int period;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] start_val;
  logic [CNT_W-1:0] end_val;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [PER_W-1:0] period_cnt;
  logic [CNT_W-1:0] count;

  int   cyc;
  int   run_base;
  int   checks;
  int   errors;
  exp_t sb[$];

  counter_seq_ctrl_if #(.CNT_W(CNT_W)) cif ();

  counter_seq_ctrl #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_val  (start_val),
    .end_val    (end_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .cnt        (cif.master),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .period_cnt (period_cnt)
  );

  // Loadable up-counter with a registered output, sitting beside the DUT.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (cif.cnt_load) count <= cif.cnt_in;
    else if (cif.cnt_enab) count <= count + 1'b1;
  end
  assign cif.cnt_out = count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc - run_base);
    end
  endtask

  // Scoreboard consumer: each done pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", cyc - run_base, -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_cycle", cyc - run_base, e.cycle);
        checkOutput("done_period", int'(period_cnt), e.period);
      end
    end
  end

  task automatic applyStimulus(input logic [CNT_W-1:0] sv, input logic [CNT_W-1:0] ev,
                               input logic ar);
    @(negedge clk);
    start       = 1'b1;
    start_val   = sv;
    end_val     = ev;
    auto_reload = ar;
    run_base    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitToCycle(input int k);
    int guard;
    guard = 0;
    while ((cyc - run_base) < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic checkDrained(input string tag);
    checkOutput(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    checks = 0; errors = 0; run_base = 0;
    rst = 1'b1; start = 1'b0; start_val = '0; end_val = '0;
    auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_load", int'(cif.cnt_load), 0);
    checkOutput("rst_cnt_in", int'(cif.cnt_in), 0);
    checkOutput("rst_period", int'(period_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic run 3 -> 8.
    sb.push_back('{cycle: 8, period: 0});
    applyStimulus(4'd3, 4'd8, 1'b0);
    checkOutput("basic_load", int'(cif.cnt_load), 1);
    checkOutput("basic_cnt_in", int'(cif.cnt_in), 3);
    waitToCycle(2);
    checkOutput("basic_first_cnt", int'(count), 3);
    waitToCycle(9);
    checkOutput("basic_busy_low", int'(busy), 0);
    checkOutput("basic_period", int'(period_cnt), 1);
    checkDrained("basic_missing_done");

    // Wrap 14 -> 1.
    sb.push_back('{cycle: 6, period: 0});
    applyStimulus(4'd14, 4'd1, 1'b0);
    waitToCycle(4);
    checkOutput("wrap_cnt_c4", int'(count), 0);
    waitToCycle(8);
    checkDrained("wrap_missing_done");

    // Start equals end: the counter is never enabled.
    sb.push_back('{cycle: 3, period: 0});
    applyStimulus(4'd5, 4'd5, 1'b0);
    waitToCycle(2);
    checkOutput("eq_enab", int'(cif.cnt_enab), 0);
    waitToCycle(5);
    checkDrained("eq_missing_done");

    // Pause for two cycles starting at cycle 4.
    sb.push_back('{cycle: 10, period: 0});
    applyStimulus(4'd3, 4'd8, 1'b0);
    waitToCycle(4);
    pause = 1'b1;
    #1 checkOutput("pause_enab", int'(cif.cnt_enab), 0);
    waitToCycle(6);
    pause = 1'b0;
    checkOutput("pause_hold", int'(count), 5);
    waitToCycle(12);
    checkDrained("pause_missing_done");

    // Auto-reload 0 -> 2, aborted at cycle 12.
    sb.push_back('{cycle: 5, period: 0});
    sb.push_back('{cycle: 10, period: 1});
    applyStimulus(4'd0, 4'd2, 1'b1);
    waitToCycle(11);
    checkOutput("ar_period", int'(period_cnt), 2);
    waitToCycle(12);
    abort = 1'b1;
    #1 checkOutput("ar_abort_enab", int'(cif.cnt_enab), 0);
    waitToCycle(13);
    abort = 1'b0;
    checkOutput("ar_aborted", int'(aborted), 1);
    checkOutput("ar_busy", int'(busy), 0);
    waitToCycle(17);
    checkOutput("ar_aborted_pulse", int'(aborted), 0);
    checkDrained("ar_missing_done");

    // Reset during RUN clears every output.
    applyStimulus(4'd3, 4'd8, 1'b0);
    waitToCycle(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_enab", int'(cif.cnt_enab), 0);
    checkOutput("mid_rst_cnt_in", int'(cif.cnt_in), 0);
    checkOutput("mid_rst_period", int'(period_cnt), 0);
    checkDrained("mid_rst_spurious");

    // A new start mid-run is ignored.
    sb.push_back('{cycle: 8, period: 0});
    applyStimulus(4'd3, 4'd8, 1'b0);
    waitToCycle(4);
    start = 1'b1; end_val = 4'd2; start_val = 4'd9;
    waitToCycle(5);
    start = 1'b0;
    waitToCycle(8);
    checkOutput("ign_end_cnt", int'(count), 8);
    checkOutput("ign_cnt_in", int'(cif.cnt_in), 3);
    waitToCycle(10);
    checkOutput("ign_period", int'(period_cnt), 1);
    checkDrained("ign_missing_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
